// File: rtl/mlp_infer_seq.sv
// rtl/mlp_infer_seq.sv - valid/ready sequencer holding a printed-MLP input for a multicycle settle window.
// Optional MLP_DOUBLE_SAMPLE_EN: samples cls_out twice and flags disagreement on m_err.
module mlp_infer_seq #(
  parameter int FEAT_W = 32,
  parameter int CLS_W  = 2,
  parameter int SETTLE = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_data,
  output logic [FEAT_W-1:0] cls_inp,
  input  logic [CLS_W-1:0]  cls_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CLS_W-1:0]  m_class,
  output logic              m_err,
  output logic              busy,
  input  logic              hist_clr,
  input  logic [CLS_W-1:0]  hist_sel,
  output logic [CNT_W-1:0]  hist_cnt
);

  localparam int NCLS = 2 ** CLS_W;

  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [FEAT_W-1:0] cls_inp_q, cls_inp_d;
  logic [CLS_W-1:0]  m_class_q, m_class_d;
  logic              m_valid_q, m_valid_d;
  logic [CNT_W-1:0]  hist_q [NCLS];
  logic [CNT_W-1:0]  hist_d [NCLS];
  logic              bump;
`ifdef MLP_DOUBLE_SAMPLE_EN
  logic              phase_q, phase_d;
  logic [CLS_W-1:0]  shadow_q, shadow_d;
  logic              m_err_q, m_err_d;
`endif

  assign s_ready = (state_q == IDLE) || ((state_q == OUT) && m_ready);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cls_inp_d = cls_inp_q;
    m_class_d = m_class_q;
    m_valid_d = m_valid_q;
    bump      = 1'b0;
`ifdef MLP_DOUBLE_SAMPLE_EN
    phase_d   = phase_q;
    shadow_d  = shadow_q;
    m_err_d   = m_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          cls_inp_d = s_data;
          cnt_d     = 8'(SETTLE - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
`ifdef MLP_DOUBLE_SAMPLE_EN
          // First pass through cnt==0 captures the shadow; the second one commits.
          if (!phase_q) begin
            shadow_d = cls_out;
            phase_d  = 1'b1;
          end else begin
            phase_d   = 1'b0;
            m_class_d = cls_out;
            m_err_d   = (shadow_q != cls_out);
            m_valid_d = 1'b1;
            state_d   = OUT;
          end
`else
          m_class_d = cls_out;
          m_valid_d = 1'b1;
          state_d   = OUT;
`endif
        end
      end
      OUT: begin
        if (m_ready) begin
          bump      = 1'b1;
          m_valid_d = 1'b0;
          if (s_valid) begin
            cls_inp_d = s_data;
            cnt_d     = 8'(SETTLE - 1);
            state_d   = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < NCLS; i++) begin
      hist_d[i] = hist_q[i];
      if (hist_clr) begin
        hist_d[i] = '0;
      end else if (bump && (m_class_q == CLS_W'(i)) && (hist_q[i] != {CNT_W{1'b1}})) begin
        hist_d[i] = hist_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cls_inp_q <= '0;
      m_class_q <= '0;
      m_valid_q <= 1'b0;
      hist_q    <= '{default: '0};
`ifdef MLP_DOUBLE_SAMPLE_EN
      phase_q   <= 1'b0;
      shadow_q  <= '0;
      m_err_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cls_inp_q <= cls_inp_d;
      m_class_q <= m_class_d;
      m_valid_q <= m_valid_d;
      hist_q    <= hist_d;
`ifdef MLP_DOUBLE_SAMPLE_EN
      phase_q   <= phase_d;
      shadow_q  <= shadow_d;
      m_err_q   <= m_err_d;
`endif
    end
  end

  assign cls_inp  = cls_inp_q;
  assign m_class  = m_class_q;
  assign m_valid  = m_valid_q;
  assign busy     = (state_q != IDLE);
  assign hist_cnt = hist_q[hist_sel];
`ifdef MLP_DOUBLE_SAMPLE_EN
  assign m_err    = m_err_q;
`else
  assign m_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_infer_seq.sv
// tb/tb_mlp_infer_seq.sv - randomized self-checking bench for mlp_infer_seq against a transaction-level model.
module tb_mlp_infer_seq;
  localparam int FEAT_W = 32;
  localparam int CLS_W  = 2;
  localparam int SETTLE = 4;
  localparam int CNT_W  = 4;
  localparam int CMAX   = 2 ** CNT_W - 1;
`ifdef MLP_DOUBLE_SAMPLE_EN
  localparam int LAT = SETTLE + 1;
`else
  localparam int LAT = SETTLE;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [FEAT_W-1:0] s_data = '0;
  logic [FEAT_W-1:0] cls_inp;
  logic [CLS_W-1:0]  cls_out;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [CLS_W-1:0]  m_class;
  logic              m_err;
  logic              busy;
  logic              hist_clr = 1'b0;
  logic [CLS_W-1:0]  hist_sel = '0;
  logic [CNT_W-1:0]  hist_cnt;

  logic              ovr_en = 1'b0;
  logic [CLS_W-1:0]  ovr_val = '0;

  int checks = 0;
  int failures = 0;
  int model_hist [4];

  mlp_infer_seq #(.FEAT_W(FEAT_W), .CLS_W(CLS_W), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cls_inp(cls_inp), .cls_out(cls_out), .m_valid(m_valid), .m_ready(m_ready),
    .m_class(m_class), .m_err(m_err), .busy(busy), .hist_clr(hist_clr),
    .hist_sel(hist_sel), .hist_cnt(hist_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in for the printed classifier: a fixed parity function of the features.
  function automatic logic [CLS_W-1:0] ref_class(input logic [FEAT_W-1:0] x);
    return {^x[31:16], ^x[15:0]};
  endfunction

  assign cls_out = ovr_en ? ovr_val : ref_class(cls_inp);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_count(input int c, input logic clr);
    if (clr) begin
      for (int i = 0; i < 4; i++) model_hist[i] = 0;
    end else if (model_hist[c] < CMAX) begin
      model_hist[c]++;
    end
  endtask

  task automatic run_one(input logic [FEAT_W-1:0] d, input logic [CLS_W-1:0] exp_cls,
                         input logic clr, input string tag);
    int n;
    s_data = d;
    s_valid = 1'b1;
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL %s_s_ready got %0b expected 1", tag, s_ready); end
    step();
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 50) begin step(); n++; end
    checks++;
    if (n != LAT) begin failures++; $display("FAIL %s_latency got %0d expected %0d", tag, n, LAT); end
    checks++;
    if (m_class !== exp_cls) begin failures++; $display("FAIL %s_class got %0d expected %0d", tag, m_class, exp_cls); end
    checks++;
    if (m_err !== 1'b0) begin failures++; $display("FAIL %s_err got %0b expected 0", tag, m_err); end
    m_ready = 1'b1;
    hist_clr = clr;
    step();
    m_ready = 1'b0;
    hist_clr = 1'b0;
    model_count(int'(exp_cls), clr);
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s_release got valid=%0b busy=%0b expected 0 0", tag, m_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) model_hist[i] = 0;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ctrl got valid=%0b busy=%0b ready=%0b expected 0 0 1", m_valid, busy, s_ready);
    end
    checks++;
    if (cls_inp !== '0 || m_class !== '0 || m_err !== 1'b0) begin
      failures++; $display("FAIL reset_data got inp=%h cls=%0d err=%0b expected 0 0 0", cls_inp, m_class, m_err);
    end
    for (int i = 0; i < 4; i++) begin
      hist_sel = CLS_W'(i);
      #1;
      checks++;
      if (hist_cnt !== '0) begin failures++; $display("FAIL reset_hist%0d got %0d expected 0", i, hist_cnt); end
    end
  endtask

  task automatic test_single();
    int n;
    ovr_en = 1'b1;
    ovr_val = 2'b10;
    s_data = 32'h1234_5678;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    checks++;
    if (cls_inp !== 32'h1234_5678) begin failures++; $display("FAIL single_cls_inp got %h expected 12345678", cls_inp); end
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL single_wait got ready=%0b busy=%0b expected 0 1", s_ready, busy);
    end
    n = 0;
    while (!m_valid && n < 50) begin step(); n++; end
    checks++;
    if (n != LAT) begin failures++; $display("FAIL single_latency got %0d expected %0d", n, LAT); end
    checks++;
    if (m_class !== 2'd2 || m_err !== 1'b0) begin
      failures++; $display("FAIL single_class got cls=%0d err=%0b expected 2 0", m_class, m_err);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    model_count(2, 1'b0);
    hist_sel = 2'd2;
    #1;
    checks++;
    if (hist_cnt !== CNT_W'(model_hist[2])) begin failures++; $display("FAIL single_hist got %0d expected %0d", hist_cnt, model_hist[2]); end
    ovr_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [CLS_W-1:0] exp_q [$];
    int res_cyc [$];
    logic [FEAT_W-1:0] last_acc;
    logic acc, hs;
    logic [CLS_W-1:0] seen, e;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    last_acc = '0;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data = $urandom;
    while (got < 10 && cyc < 300) begin
      if (sent >= 10) s_valid = 1'b0;
      #1;
      acc = s_valid && s_ready;
      hs = m_valid && m_ready;
      seen = m_class;
      if (busy && !m_valid) begin
        checks++;
        if (s_ready !== 1'b0 || cls_inp !== last_acc) begin
          failures++; $display("FAIL b2b_wait got ready=%0b inp=%h expected 0 %h", s_ready, cls_inp, last_acc);
        end
      end
      step();
      cyc++;
      if (acc) begin
        exp_q.push_back(ref_class(s_data));
        last_acc = s_data;
        sent++;
        s_data = $urandom;
      end
      if (hs) begin
        e = exp_q.pop_front();
        checks++;
        if (seen !== e) begin failures++; $display("FAIL b2b_class%0d got %0d expected %0d", got, seen, e); end
        model_count(int'(e), 1'b0);
        res_cyc.push_back(cyc);
        got++;
      end
    end
    m_ready = 1'b0;
    s_valid = 1'b0;
    checks++;
    if (got != 10) begin failures++; $display("FAIL b2b_count got %0d expected 10", got); end
    for (int i = 1; i < res_cyc.size(); i++) begin
      checks++;
      if (res_cyc[i] - res_cyc[i-1] != LAT + 1) begin
        failures++; $display("FAIL b2b_interval%0d got %0d expected %0d", i, res_cyc[i] - res_cyc[i-1], LAT + 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      hist_sel = CLS_W'(i);
      #1;
      checks++;
      if (hist_cnt !== CNT_W'(model_hist[i])) begin failures++; $display("FAIL b2b_hist%0d got %0d expected %0d", i, hist_cnt, model_hist[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [FEAT_W-1:0] d;
    logic [CLS_W-1:0] e;
    int n;
    d = $urandom;
    e = ref_class(d);
    hist_sel = e;
    s_data = d;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 50) begin step(); n++; end
    s_valid = 1'b1;
    s_data = ~d;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (m_valid !== 1'b1 || m_class !== e || s_ready !== 1'b0 || cls_inp !== d || hist_cnt !== CNT_W'(model_hist[e])) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%0b cls=%0d rdy=%0b inp=%h cnt=%0d expected 1 %0d 0 %h %0d",
                 c, m_valid, m_class, s_ready, cls_inp, hist_cnt, e, d, model_hist[e]);
      end
      step();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    model_count(int'(e), 1'b0);
    checks++;
    if (hist_cnt !== CNT_W'(model_hist[e]) || m_valid !== 1'b0) begin
      failures++; $display("FAIL bp_release got cnt=%0d v=%0b expected %0d 0", hist_cnt, m_valid, model_hist[e]);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [FEAT_W-1:0] d;
    int spurious;
    d = $urandom | 32'h1;
    s_data = d;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) model_hist[i] = 0;
    checks++;
    if (m_valid !== 1'b0 || cls_inp !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_mid got v=%0b inp=%h busy=%0b expected 0 0 0", m_valid, cls_inp, busy);
    end
    for (int i = 0; i < 4; i++) begin
      hist_sel = CLS_W'(i);
      #1;
      checks++;
      if (hist_cnt !== '0) begin failures++; $display("FAIL rst_mid_hist%0d got %0d expected 0", i, hist_cnt); end
    end
    spurious = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_valid) spurious++;
      step();
    end
    checks++;
    if (spurious != 0) begin failures++; $display("FAIL rst_mid_spurious got %0d expected 0", spurious); end
    d = $urandom;
    run_one(d, ref_class(d), 1'b0, "rst_mid_next");
  endtask

  task automatic test_saturation();
    ovr_en = 1'b1;
    ovr_val = 2'd1;
    for (int k = 0; k < 17; k++) run_one($urandom, 2'd1, 1'b0, "sat");
    hist_sel = 2'd1;
    #1;
    checks++;
    if (hist_cnt !== CNT_W'(CMAX)) begin failures++; $display("FAIL sat_value got %0d expected %0d", hist_cnt, CMAX); end
    run_one($urandom, 2'd1, 1'b1, "sat_clr");
    for (int i = 0; i < 4; i++) begin
      hist_sel = CLS_W'(i);
      #1;
      checks++;
      if (hist_cnt !== '0) begin failures++; $display("FAIL sat_clr_hist%0d got %0d expected 0", i, hist_cnt); end
    end
    ovr_en = 1'b0;
  endtask

  task automatic test_double_sample();
`ifdef MLP_DOUBLE_SAMPLE_EN
    ovr_en = 1'b1;
    ovr_val = 2'd1;
    s_data = $urandom;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    repeat (SETTLE) step();
    checks++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL ds_early got %0b expected 0", m_valid); end
    ovr_val = 2'd0;
    step();
    checks++;
    if (m_valid !== 1'b1 || m_class !== 2'd0 || m_err !== 1'b1) begin
      failures++; $display("FAIL ds_mismatch got v=%0b cls=%0d err=%0b expected 1 0 1", m_valid, m_class, m_err);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    model_count(0, 1'b0);
    hist_sel = 2'd0;
    #1;
    checks++;
    if (hist_cnt !== CNT_W'(model_hist[0])) begin failures++; $display("FAIL ds_hist got %0d expected %0d", hist_cnt, model_hist[0]); end
    run_one($urandom, 2'd0, 1'b0, "ds_stable");
    ovr_en = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_wait();
    test_saturation();
    test_double_sample();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mlp_infer_seq.md
Name: mlp_infer_seq

Overview:
- Sequencer for a combinational printed-MLP classifier (32-bit packed input of 8 x 4-bit features, 2-bit class index).
- Accepts feature vectors on a valid/ready stream and holds each one stable on the classifier input for a programmable multicycle settle window, because the printed combinational path cannot close timing in one cycle.
- Registers the resulting class, returns it on an output valid/ready stream, and keeps per-class result counters for accuracy and fault-campaign statistics.

Parameters:
- FEAT_W, 32, packed feature vector width (8 features x 4 bits).
- CLS_W, 2, class index width; number of histogram counters is 2**CLS_W.
- SETTLE, 4, number of clock edges between driving cls_inp and sampling cls_out; legal range is 1..255.
- CNT_W, 16, width of each histogram counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- s_valid  in  1  input feature vector valid.
- s_ready  out  1  sequencer can accept a feature vector.
- s_data  in  FEAT_W  input feature vector.
- cls_inp  out  FEAT_W  registered drive to the classifier input.
- cls_out  in  CLS_W  classifier result (combinational from cls_inp).
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_class  out  CLS_W  registered class index.
- m_err  out  1  double-sample mismatch flag; tied to 0 without the macro.
- busy  out  1  high in any state other than IDLE.
- hist_clr  in  1  synchronous clear of all histogram counters.
- hist_sel  in  CLS_W  histogram counter select.
- hist_cnt  out  CNT_W  combinational read of counter[hist_sel].

Behaviour:
- Reset (rst_n=0 at an edge):
  - FSM goes to IDLE; cls_inp=0, m_class=0, m_valid=0, m_err=0, settle counter=0, all histogram counters=0.
  - Reset mid-operation drops any in-flight sample; no result is produced for it.
- FSM states: IDLE, WAIT, OUT.
- IDLE:
  - s_ready=1.
  - On s_valid: cls_inp<=s_data, cnt<=SETTLE-1, go to WAIT.
- WAIT:
  - s_ready=0; cls_inp is held constant.
  - If cnt!=0: cnt decrements by 1.
  - If cnt==0: m_class<=cls_out, m_valid<=1, go to OUT.
  - Resulting timing: m_class samples cls_out exactly SETTLE edges after the accepting edge, and m_valid is high from that edge onward.
  - SETTLE=1: WAIT lasts exactly one cycle.
- OUT:
  - m_valid=1; m_class and m_err are held stable until m_ready.
  - On m_ready: the histogram counter indexed by m_class increments; m_valid<=0.
  - s_ready=m_ready in OUT, so a new vector can be accepted on the same edge as the result handshake.
    - If s_valid is also high: load cls_inp, go to WAIT.
    - Otherwise: go to IDLE.
  - Back-to-back throughput: one result per SETTLE+1 cycles when m_ready is held high.
- Histogram:
  - Counters saturate at 2**CNT_W-1 and do not wrap.
  - hist_clr clears all counters at the next edge.
  - If hist_clr coincides with an increment, clear wins and the counter reads 0.
  - Out-of-range class codes (e.g. 3 from a 3-class net) are counted normally.
- cls_inp changes only on an accepting edge, which guarantees the multicycle path constraint from cls_inp to cls_out.

Optional Feature:
- Macro: MLP_DOUBLE_SAMPLE_EN.
- Defined:
  - WAIT is extended by one cycle.
  - cls_out is sampled at SETTLE edges into a shadow register and again at SETTLE+1 edges into m_class.
  - m_err<=(shadow!=second sample), registered alongside m_class, for timing-error / fault detection.
  - The histogram counts the second sample.
  - m_valid rises SETTLE+1 edges after acceptance.
- Undefined: no shadow register; m_err is constant 0; latency is SETTLE.

Test Plan:
1. Reset then single sample, SETTLE=4: s_data=32'h1234_5678, cls_out stub returns 2'b10 → cls_inp=32'h1234_5678 after the accepting edge, m_valid rises 4 edges later, m_class=2, hist_cnt[2]=1 after the handshake.
2. Back-to-back stream, m_ready=1, 10 vectors → one result every 5 cycles; s_ready low throughout each WAIT; cls_inp never changes during WAIT.
3. Backpressure: m_ready=0 for 20 cycles in OUT → m_valid, m_class and s_ready=0 stay stable; no histogram increment until m_ready=1.
4. Saturation and clear: CNT_W=4, 17 results of class 1 → hist_cnt[1]=15. Then hist_clr on the same edge as an increment → hist_cnt[1]=0.
5. Reset mid-WAIT (rst_n=0 at cnt=2) → IDLE, m_valid=0, cls_inp=0, counters=0; the next accepted sample completes normally.
6. With MLP_DOUBLE_SAMPLE_EN: cls_out stub changes 1→0 between edge SETTLE and edge SETTLE+1 → m_class=0, m_err=1, latency SETTLE+1. With a stable cls_out → m_err=0.
